rv32_fetch_sequencer: RTL and testbench

Parametrised instruction-fetch front end for the microcoded RV32 core. It assembles one ILEN-bit instruction from BUS_BITS-wide memory beats using a req/ack handshake, with optional per-beat byte swapping. It presents the instruction, its PC and a registered dispatch class to the microcode sequencer over a valid/ready handshake. A PC redirect flushes any fetch in progress. It generalises the fixed 16-bit, two-beat instruction latch to 8/16/32-bit buses and adds wait-state and backpressure support.

---
 rtl/rv32_fetch_sequencer_if.sv | 36 +++
 rtl/rv32_fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_rv32_fetch_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_sequencer_if.sv
// rv32_fetch_sequencer_if: memory beat bus plus instruction hand-off to the microcode sequencer
interface rv32_fetch_sequencer_if #(
    parameter int XLEN     = 32,
    parameter int ILEN     = 32,
    parameter int BUS_BITS = 16
);
    logic [XLEN-1:0]     mem_addr_o;
    logic                mem_req_o;
    logic                mem_ack_i;
    logic [BUS_BITS-1:0] mem_data_i;
    logic [ILEN-1:0]     instr_o;
    logic [XLEN-1:0]     instr_pc_o;
    logic                instr_valid_o;
    logic                instr_ready_i;
    logic [3:0]          dispatch_o;
    logic                illegal_o;
    logic                instr_compressed_o;

    // Fetch unit side: drives the beat request and the assembled instruction
    modport master (
        output mem_addr_o, mem_req_o,
        input  mem_ack_i, mem_data_i,
        output instr_o, instr_pc_o, instr_valid_o,
        input  instr_ready_i,
        output dispatch_o, illegal_o, instr_compressed_o
    );

    // Memory and sequencer side
    modport slave (
        input  mem_addr_o, mem_req_o,
        output mem_ack_i, mem_data_i,
        input  instr_o, instr_pc_o, instr_valid_o,
        output instr_ready_i,
        input  dispatch_o, illegal_o, instr_compressed_o
    );
endinterface

// File: rtl/rv32_fetch_sequencer.sv
// rv32_fetch_sequencer: beat-assembling instruction fetch with dispatch decode; RV32_FETCH_RVC_EN enables compressed early completion
module rv32_fetch_sequencer #(
    parameter int               XLEN         = 32,
    parameter int               ILEN         = 32,
    parameter int               BUS_BITS     = 16,
    parameter bit               BYTE_SWAP    = 1'b1,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input logic                   clk_i,
    input logic                   reset_ni,
    input logic [XLEN-1:0]        pc_i,
    input logic                   pc_load_i,
    rv32_fetch_sequencer_if.master bus
);
    localparam int BEATS = ILEN / BUS_BITS;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int BYTES = BUS_BITS / 8;
`ifdef RV32_FETCH_RVC_EN
    localparam int A         = 1;
    localparam int HALF_BEAT = 16 / BUS_BITS - 1;
`else
    localparam int A = 2;
`endif

    if ((BUS_BITS != 8 && BUS_BITS != 16 && BUS_BITS != 32) || (ILEN % BUS_BITS != 0)) begin : g_bad_bus
        $error("rv32_fetch_sequencer: BUS_BITS must be 8/16/32 and divide ILEN");
    end
`ifdef RV32_FETCH_RVC_EN
    if (BUS_BITS == 32) begin : g_bad_rvc
        $error("rv32_fetch_sequencer: compressed support needs BUS_BITS of 8 or 16");
    end
`endif

    typedef enum logic {FETCH, VALID} state_t;

    state_t              state_q;
    logic [XLEN-1:0]     pc_q;
    logic [BW-1:0]       beat_q;
    logic [ILEN-1:0]     instr_q;
    logic [XLEN-1:0]     ipc_q;
    logic                req_q;
    logic                valid_q;
    logic [3:0]          disp_q;
    logic                ill_q;
    logic                comp_q;

    logic [BUS_BITS-1:0] beat_d;
    logic [ILEN-1:0]     instr_d;
    logic [4:0]          cls_d;
    logic                ack_d;
    logic                last_d;
    logic                comp_d;
    logic [A-1:0]        unused_pc_bits;

    assign unused_pc_bits = pc_i[A-1:0];

    // {illegal, dispatch class} from the base opcode; non-32-bit encodings are illegal here
    function automatic logic [4:0] classify(input logic [ILEN-1:0] w);
        logic [3:0] d;
        case (w[6:2])
            5'b00000: d = 4'd1;
            5'b00011: d = 4'd2;
            5'b00100: d = 4'd3;
            5'b00101: d = 4'd4;
            5'b01000: d = 4'd5;
            5'b01100: d = 4'd6;
            5'b01101: d = 4'd7;
            5'b11000: d = 4'd8;
            5'b11001: d = 4'd9;
            5'b11011: d = 4'd10;
            5'b11100: d = 4'd11;
            default:  d = 4'd0;
        endcase
        if (w[1:0] != 2'b11) d = 4'd0;
        return {d == 4'd0, d};
    endfunction

    // Byte-reverse the incoming beat when requested and merge it into the partial instruction
    always_comb begin
        beat_d = bus.mem_data_i;
        if (BYTE_SWAP)
            for (int b = 0; b < BYTES; b++)
                beat_d[8*b +: 8] = bus.mem_data_i[BUS_BITS-8-8*b +: 8];
        instr_d = instr_q;
        instr_d[beat_q * BUS_BITS +: BUS_BITS] = beat_d;
    end

    assign cls_d  = classify(instr_d);
    assign ack_d  = bus.mem_ack_i & req_q & (state_q == FETCH);
    assign last_d = beat_q == BW'(BEATS - 1);
`ifdef RV32_FETCH_RVC_EN
    assign comp_d = (beat_q == BW'(HALF_BEAT)) & (instr_d[1:0] != 2'b11);
`else
    assign comp_d = 1'b0;
`endif

    // Fetch/present FSM; redirect overrides any ack or hand-off in the same cycle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            beat_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            disp_q  <= '0;
            ill_q   <= 1'b0;
            comp_q  <= 1'b0;
        end else if (pc_load_i) begin
            state_q <= FETCH;
            pc_q    <= {pc_i[XLEN-1:A], {A{1'b0}}};
            beat_q  <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else if (state_q == FETCH) begin
            req_q <= 1'b1;
            if (ack_d) begin
                instr_q <= comp_d ? {{(ILEN-16){1'b0}}, instr_d[15:0]} : instr_d;
                beat_q  <= beat_q + 1'b1;
                if (last_d || comp_d) begin
                    state_q <= VALID;
                    req_q   <= 1'b0;
                    valid_q <= 1'b1;
                    ipc_q   <= pc_q;
                    disp_q  <= comp_d ? 4'd12 : cls_d[3:0];
                    ill_q   <= comp_d ? 1'b0 : cls_d[4];
                    comp_q  <= comp_d;
                end
            end
        end else if (bus.instr_ready_i) begin
            state_q <= FETCH;
            pc_q    <= pc_q + (comp_q ? XLEN'(2) : XLEN'(ILEN / 8));
            beat_q  <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end
    end

    assign bus.mem_addr_o         = pc_q + XLEN'(beat_q * BYTES);
    assign bus.mem_req_o          = req_q;
    assign bus.instr_o            = instr_q;
    assign bus.instr_pc_o         = ipc_q;
    assign bus.instr_valid_o      = valid_q;
    assign bus.dispatch_o         = disp_q;
    assign bus.illegal_o          = ill_q;
    assign bus.instr_compressed_o = comp_q;
endmodule

// File: tb/tb_rv32_fetch_sequencer.sv
// tb_rv32_fetch_sequencer: directed vectors for 16-bit and 8-bit bus builds of the fetch sequencer
module tb_rv32_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc16 = '0;
    logic        ld16 = 1'b0;
    logic [31:0] pc8 = '0;
    logic        ld8 = 1'b0;
    int          errs = 0;
    int          checks = 0;
    logic [7:0]  m16 [512];
    logic [7:0]  m8 [4];

    typedef struct {
        logic [31:0] word;
        logic [3:0]  disp;
        logic        ill;
    } vec_t;
    vec_t vt [14];

    always #5 clk = ~clk;

    rv32_fetch_sequencer_if #(.XLEN(32), .ILEN(32), .BUS_BITS(16)) b16 ();
    rv32_fetch_sequencer_if #(.XLEN(32), .ILEN(32), .BUS_BITS(8))  b8 ();

    rv32_fetch_sequencer #(.XLEN(32), .ILEN(32), .BUS_BITS(16), .BYTE_SWAP(1'b1), .RESET_VECTOR(32'h0)) dut16 (
        .clk_i(clk), .reset_ni(rst_n), .pc_i(pc16), .pc_load_i(ld16), .bus(b16.master));

    rv32_fetch_sequencer #(.XLEN(32), .ILEN(32), .BUS_BITS(8), .BYTE_SWAP(1'b1), .RESET_VECTOR(32'h0)) dut8 (
        .clk_i(clk), .reset_ni(rst_n), .pc_i(pc8), .pc_load_i(ld8), .bus(b8.master));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Little-endian instruction bytes; the bus presents them big-endian so the swap restores order
    task automatic put16(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) m16[(a[8:0] + 9'(k))] = w[8*k +: 8];
    endtask

    function automatic logic [15:0] rd16(input logic [31:0] a);
        return {m16[a[8:0]], m16[a[8:0] + 9'd1]};
    endfunction

    // Serve beats from the current negedge until valid; latency counts the first req cycle as 1
    task automatic fetch16(input logic [31:0] pc, input int stall_beat, input int stall_n, input int exp_lat);
        int cyc, beat, st;
        bit done;
        cyc = 0; beat = 0; st = 0; done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            b16.mem_ack_i = 1'b0;
            if (b16.instr_valid_o) done = 1'b1;
            else begin
                if (b16.mem_req_o) begin
                    cyc++;
                    chk("beat_addr", b16.mem_addr_o, pc + 32'(2 * beat));
                    if (beat == stall_beat && st < stall_n) st++;
                    else begin
                        b16.mem_ack_i  = 1'b1;
                        b16.mem_data_i = rd16(b16.mem_addr_o);
                        beat++;
                    end
                end
                @(negedge clk);
            end
        end
        b16.mem_ack_i = 1'b0;
        chk("valid_reached", 32'(done), 32'd1);
        chk("latency", 32'(cyc + 1), 32'(exp_lat));
    endtask

    // Hold ready low for delay cycles checking stability, then hand off
    task automatic hs16(input int delay);
        logic [31:0] i0, p0;
        logic [3:0]  d0;
        i0 = b16.instr_o; p0 = b16.instr_pc_o; d0 = b16.dispatch_o;
        for (int k = 0; k < delay; k++) begin
            b16.instr_ready_i = 1'b0;
            @(negedge clk);
            chk("bp_valid", 32'(b16.instr_valid_o), 32'd1);
            chk("bp_req", 32'(b16.mem_req_o), 32'd0);
            chk("bp_instr", b16.instr_o, i0);
            chk("bp_pc", b16.instr_pc_o, p0);
            chk("bp_disp", 32'(b16.dispatch_o), 32'(d0));
        end
        b16.instr_ready_i = 1'b1;
        @(negedge clk);
        b16.instr_ready_i = 1'b0;
        chk("hs_valid", 32'(b16.instr_valid_o), 32'd0);
        chk("hs_req", 32'(b16.mem_req_o), 32'd1);
    endtask

    task automatic chk_out(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] d, input logic il, input logic c);
        chk("instr", b16.instr_o, w);
        chk("instr_pc", b16.instr_pc_o, pc);
        chk("dispatch", 32'(b16.dispatch_o), 32'(d));
        chk("illegal", 32'(b16.illegal_o), 32'(il));
        chk("compressed", 32'(b16.instr_compressed_o), 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int beat, cyc;
        bit done;
        vt[0]  = '{32'h00012203, 4'd1,  1'b0};
        vt[1]  = '{32'h0FF0000F, 4'd2,  1'b0};
        vt[2]  = '{32'h00A00113, 4'd3,  1'b0};
        vt[3]  = '{32'h00001197, 4'd4,  1'b0};
        vt[4]  = '{32'h00112623, 4'd5,  1'b0};
        vt[5]  = '{32'h002081B3, 4'd6,  1'b0};
        vt[6]  = '{32'h123452B7, 4'd7,  1'b0};
        vt[7]  = '{32'h00208463, 4'd8,  1'b0};
        vt[8]  = '{32'h000080E7, 4'd9,  1'b0};
        vt[9]  = '{32'h008000EF, 4'd10, 1'b0};
        vt[10] = '{32'h00000073, 4'd11, 1'b0};
        vt[11] = '{32'h0000000B, 4'd0,  1'b1};
        vt[12] = '{32'h0000007F, 4'd0,  1'b1};
        vt[13] = '{32'h00000057, 4'd0,  1'b1};
        for (int i = 0; i < 512; i++) m16[i] = 8'h00;
        put16(32'h0, 32'h00500093);
        for (int i = 0; i < 14; i++) put16(32'(4 + 4 * i), vt[i].word);
        put16(32'h100, 32'h0000006F);
        put16(32'h1FC, 32'h000000B7);
        put16(32'h180, 32'h00004505);
        m8[0] = 8'h7F; m8[1] = 8'h00; m8[2] = 8'h00; m8[3] = 8'h00;
        b16.mem_ack_i = 1'b0; b16.mem_data_i = '0; b16.instr_ready_i = 1'b0;
        b8.mem_ack_i = 1'b0;  b8.mem_data_i = '0;  b8.instr_ready_i = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(b16.mem_req_o), 32'd0);
        chk("rst_addr", b16.mem_addr_o, 32'h0);
        chk("rst_valid", 32'(b16.instr_valid_o), 32'd0);
        chk_out(32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        chk("rst_req8", 32'(b8.mem_req_o), 32'd0);
        rst_n = 1'b1;
        #1 chk("req_not_comb", 32'(b16.mem_req_o), 32'd0);
        @(negedge clk);
        chk("req_first_edge", 32'(b16.mem_req_o), 32'd1);

        // Basic two-beat fetch with byte swap
        fetch16(32'h0, -1, 0, 3);
        chk_out(32'h00500093, 32'h0, 4'd3, 1'b0, 1'b0);
        hs16(0);
        chk("next_addr", b16.mem_addr_o, 32'h4);

        // Reset between beats restarts at the reset vector
        b16.mem_ack_i = 1'b1; b16.mem_data_i = rd16(32'h4);
        @(negedge clk);
        b16.mem_ack_i = 1'b0;
        chk("mid_beat1_addr", b16.mem_addr_o, 32'h6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(b16.mem_req_o), 32'd0);
        chk("mid_rst_addr", b16.mem_addr_o, 32'h0);
        chk("mid_rst_valid", 32'(b16.instr_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Four wait states on beat 1, then backpressure
        fetch16(32'h0, 1, 4, 7);
        chk_out(32'h00500093, 32'h0, 4'd3, 1'b0, 1'b0);
        hs16(5);
        chk("bp_next_addr", b16.mem_addr_o, 32'h4);

        // Dispatch class table
        for (int i = 0; i < 14; i++) begin
            fetch16(32'(4 + 4 * i), -1, 0, 3);
            chk_out(vt[i].word, 32'(4 + 4 * i), vt[i].disp, vt[i].ill, 1'b0);
            hs16(0);
            chk("tbl_next_addr", b16.mem_addr_o, 32'(8 + 4 * i));
        end

        // Redirect in the same cycle as the beat-0 ack
        b16.mem_ack_i = 1'b1; b16.mem_data_i = rd16(b16.mem_addr_o);
        pc16 = 32'h100; ld16 = 1'b1;
        @(negedge clk);
        b16.mem_ack_i = 1'b0; ld16 = 1'b0;
        chk("redir_addr", b16.mem_addr_o, 32'h100);
        chk("redir_req", 32'(b16.mem_req_o), 32'd1);
        fetch16(32'h100, -1, 0, 3);
        chk_out(32'h0000006F, 32'h100, 4'd10, 1'b0, 1'b0);

        // Redirect beats a same-cycle hand-off
        b16.instr_ready_i = 1'b1; pc16 = 32'hFFFF_FFFC; ld16 = 1'b1;
        @(negedge clk);
        b16.instr_ready_i = 1'b0; ld16 = 1'b0;
        chk("redir_vs_hs_valid", 32'(b16.instr_valid_o), 32'd0);
        chk("redir_vs_hs_addr", b16.mem_addr_o, 32'hFFFF_FFFC);

        // Alignment of the redirect target
        pc16 = 32'h103; ld16 = 1'b1;
        @(negedge clk);
        ld16 = 1'b0;
`ifdef RV32_FETCH_RVC_EN
        chk("align", b16.mem_addr_o, 32'h102);
`else
        chk("align", b16.mem_addr_o, 32'h100);
`endif

        // PC wraps past the top of the address space
        pc16 = 32'hFFFF_FFFC; ld16 = 1'b1;
        @(negedge clk);
        ld16 = 1'b0;
        fetch16(32'hFFFF_FFFC, -1, 0, 3);
        chk_out(32'h000000B7, 32'hFFFF_FFFC, 4'd7, 1'b0, 1'b0);
        hs16(0);
        chk("wrap_addr", b16.mem_addr_o, 32'h0);

        // Compressed halfword
        pc16 = 32'h180; ld16 = 1'b1;
        @(negedge clk);
        ld16 = 1'b0;
`ifdef RV32_FETCH_RVC_EN
        fetch16(32'h180, -1, 0, 2);
        chk_out(32'h00004505, 32'h180, 4'd12, 1'b0, 1'b1);
        hs16(0);
        chk("rvc_next_addr", b16.mem_addr_o, 32'h182);
`else
        fetch16(32'h180, -1, 0, 3);
        chk_out(32'h00004505, 32'h180, 4'd0, 1'b1, 1'b0);
        hs16(0);
        chk("rvc_next_addr", b16.mem_addr_o, 32'h184);
`endif

        // 8-bit bus: it has been stalled at its reset vector the whole time
        beat = 0; cyc = 0; done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            b8.mem_ack_i = 1'b0;
            if (b8.instr_valid_o) done = 1'b1;
            else begin
                if (b8.mem_req_o) begin
                    cyc++;
                    chk("b8_addr", b8.mem_addr_o, 32'(beat));
                    b8.mem_ack_i  = 1'b1;
                    b8.mem_data_i = m8[beat & 3];
                    beat++;
                end
                @(negedge clk);
            end
        end
        b8.mem_ack_i = 1'b0;
        chk("b8_valid", 32'(done), 32'd1);
        chk("b8_latency", 32'(cyc + 1), 32'd5);
        chk("b8_instr", b8.instr_o, 32'h0000007F);
        chk("b8_illegal", 32'(b8.illegal_o), 32'd1);
        chk("b8_dispatch", 32'(b8.dispatch_o), 32'd0);
        chk("b8_pc", b8.instr_pc_o, 32'h0);
        b8.instr_ready_i = 1'b1;
        @(negedge clk);
        b8.instr_ready_i = 1'b0;
        chk("b8_next_addr", b8.mem_addr_o, 32'h4);
        chk("b8_next_req", 32'(b8.mem_req_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
